// File: rtl/l2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg / l2_arbiter_if
// Description : Shared L2 request/answer types plus the bundle of handshake
//               channels around the L2 arbiter.
//               memory_pkg    - request/answer structs and their type codes.
//               l2_arbiter_if - three requester request channels, the L2
//                               request/answer channels and three routed
//                               answer channels.
//               Modports:
//                 master - arbiter view (consumes requests, drives L2 req,
//                          consumes L2 answers, drives routed answers)
//                 slave  - environment view (mirror of master)
// Revision    : 1.0 - initial release
// ============================================================================

package memory_pkg;

  localparam int PADDR_W   = 32;
  localparam int LINE_W    = 64;
  localparam int WBB_TAG_W = 3;

  typedef enum logic [1:0] {
    PTWLoad    = 2'd0,
    DReadLine  = 2'd1,
    DWriteLine = 2'd2,
    IReadLine  = 2'd3
  } l2arb_req_type_t;

  typedef enum logic [2:0] {
    l2arb_s0_ILineRead    = 3'd0,
    l2arb_s0_DLineRead    = 3'd1,
    l2arb_s0_DLineWritten = 3'd2,
    l2arb_s0_DWbbWakeUp   = 3'd3,
    l2arb_s0_PTWLoad      = 3'd4
  } l2arb_ans_type_t;

  typedef struct packed {
    logic                 valid;
    l2arb_req_type_t      req_type;
    logic [PADDR_W-1:0]   paddr;
    logic [LINE_W-1:0]    data;
    logic [WBB_TAG_W-1:0] wbb_tag;
  } l2arb_l2c_req_t;

  typedef struct packed {
    logic                 valid;
    l2arb_ans_type_t      ans_type;
    logic [PADDR_W-1:0]   paddr;
    logic [LINE_W-1:0]    data;
    logic [WBB_TAG_W-1:0] wbb_tag;
  } l2c_l2arb_ans_t;

endpackage

interface l2_arbiter_if;
  import memory_pkg::*;

  // Requester -> arbiter
  l2arb_l2c_req_t ptw_l2arb_req_i;
  logic           l2arb_ptw_req_rdy_o;
  l2arb_l2c_req_t dc_l2arb_req_i;
  logic           l2arb_dc_req_rdy_o;
  l2arb_l2c_req_t ic_l2arb_req_i;
  logic           l2arb_ic_req_rdy_o;

  // Arbiter <-> L2 Cache
  l2arb_l2c_req_t l2arb_l2c_req_o;
  logic           l2c_l2arb_req_rdy_i;
  l2c_l2arb_ans_t l2c_l2arb_ans_i;
  logic           l2arb_l2c_ans_rdy_o;

  // Arbiter -> requester answers
  l2c_l2arb_ans_t l2arb_ptw_ans_o;
  logic           ptw_l2arb_ans_rdy_i;
  l2c_l2arb_ans_t l2arb_dc_ans_o;
  logic           dc_l2arb_ans_rdy_i;
  l2c_l2arb_ans_t l2arb_ic_ans_o;
  logic           ic_l2arb_ans_rdy_i;

  modport master (
    input  ptw_l2arb_req_i, dc_l2arb_req_i, ic_l2arb_req_i,
    output l2arb_ptw_req_rdy_o, l2arb_dc_req_rdy_o, l2arb_ic_req_rdy_o,
    output l2arb_l2c_req_o,
    input  l2c_l2arb_req_rdy_i,
    input  l2c_l2arb_ans_i,
    output l2arb_l2c_ans_rdy_o,
    output l2arb_ptw_ans_o, l2arb_dc_ans_o, l2arb_ic_ans_o,
    input  ptw_l2arb_ans_rdy_i, dc_l2arb_ans_rdy_i, ic_l2arb_ans_rdy_i
  );

  modport slave (
    output ptw_l2arb_req_i, dc_l2arb_req_i, ic_l2arb_req_i,
    input  l2arb_ptw_req_rdy_o, l2arb_dc_req_rdy_o, l2arb_ic_req_rdy_o,
    input  l2arb_l2c_req_o,
    output l2c_l2arb_req_rdy_i,
    output l2c_l2arb_ans_i,
    input  l2arb_l2c_ans_rdy_o,
    input  l2arb_ptw_ans_o, l2arb_dc_ans_o, l2arb_ic_ans_o,
    output ptw_l2arb_ans_rdy_i, dc_l2arb_ans_rdy_i, ic_l2arb_ans_rdy_i
  );

endinterface

`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_arbiter
// Description : Round-robin arbiter placing PTW / D-cache / I-cache requests
//               onto the single L2 Cache request channel through a one-entry
//               output register, and routing L2 answers back by answer type
//               into one-entry per-destination answer buffers.
// Ports       :
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   flush_i  in   pipeline flush (drops non-write-back work, blocks grants)
//   bus      l2_arbiter_if.master
//              requests  : ptw/dc/ic_l2arb_req_i  -> l2arb_*_req_rdy_o
//              L2 req    : l2arb_l2c_req_o        <- l2c_l2arb_req_rdy_i
//              L2 answer : l2c_l2arb_ans_i        -> l2arb_l2c_ans_rdy_o
//              answers   : l2arb_ptw/dc/ic_ans_o  <- *_l2arb_ans_rdy_i
// Revision    : 1.0 - initial release
// ============================================================================

module l2_arbiter
  import memory_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  l2_arbiter_if.master bus
);

  // Requester indices double as round-robin pointer values.
  localparam logic [1:0] SRC_PTW = 2'd0;
  localparam logic [1:0] SRC_DC  = 2'd1;
  localparam logic [1:0] SRC_IC  = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  l2arb_l2c_req_t req_q, req_d;
  l2c_l2arb_ans_t ptw_ans_q, ptw_ans_d;
  l2c_l2arb_ans_t dc_ans_q, dc_ans_d;
  l2c_l2arb_ans_t ic_ans_q, ic_ans_d;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  logic [2:0]     src_vld;
  logic           drain;
  logic           can_load;
  logic           accept;
  logic           grant_vld;
  logic [1:0]     grant_idx;
  logic [1:0]     grant_next;
  l2arb_l2c_req_t grant_req;

  // Reduce a value in 0..5 to 0..2.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] w;
    w = (v >= 3'd3) ? (v - 3'd3) : v;
    return w[1:0];
  endfunction

  assign src_vld = {bus.ic_l2arb_req_i.valid,
                    bus.dc_l2arb_req_i.valid,
                    bus.ptw_l2arb_req_i.valid};

  assign drain    = req_q.valid && bus.l2c_l2arb_req_rdy_i;
  assign can_load = (!req_q.valid || drain) && !flush_i;

  // First valid source scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  always_comb begin
    logic [1:0] cand;
    grant_vld = 1'b0;
    grant_idx = SRC_PTW;
    cand      = SRC_PTW;
    for (int unsigned off = 0; off < 3; off++) begin
      cand = wrap3({1'b0, rr_ptr_q} + off[2:0]);
      if (!grant_vld && src_vld[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      SRC_DC:  grant_req = bus.dc_l2arb_req_i;
      SRC_IC:  grant_req = bus.ic_l2arb_req_i;
      default: grant_req = bus.ptw_l2arb_req_i;
    endcase
  end

  // Ready goes only to the granted source; a grant with can_load is an accept
  // because the granted source is by construction valid.
  assign accept = can_load && grant_vld;

  assign bus.l2arb_ptw_req_rdy_o = accept && (grant_idx == SRC_PTW);
  assign bus.l2arb_dc_req_rdy_o  = accept && (grant_idx == SRC_DC);
  assign bus.l2arb_ic_req_rdy_o  = accept && (grant_idx == SRC_IC);

  assign grant_next = (grant_idx == SRC_IC) ? SRC_PTW : (grant_idx + 2'd1);
  assign rr_ptr_d   = accept ? grant_next : rr_ptr_q;

  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d = grant_req;
    end else if (drain) begin
      req_d.valid = 1'b0;
    end
    // A pending write-back must survive a flush; anything else is dropped.
    if (flush_i && (req_q.req_type != DWriteLine)) begin
      req_d = '0;
    end
  end

  assign bus.l2arb_l2c_req_o = req_q;

  // --------------------------------------------------------------------------
  // Answer side
  // --------------------------------------------------------------------------
  logic to_ptw;
  logic to_dc;
  logic to_ic;
  logic ans_rdy;
  logic ans_hs;

  always_comb begin
    to_ptw = 1'b0;
    to_dc  = 1'b0;
    to_ic  = 1'b0;
    case (bus.l2c_l2arb_ans_i.ans_type)
      l2arb_s0_ILineRead:    to_ic  = 1'b1;
      l2arb_s0_DLineRead,
      l2arb_s0_DLineWritten,
      l2arb_s0_DWbbWakeUp:   to_dc  = 1'b1;
      l2arb_s0_PTWLoad:      to_ptw = 1'b1;
      default: ;
    endcase
  end

  // Ready depends only on the addressed destination, never on answer valid.
  // Undefined answer types have no destination and are accepted and dropped
  // so they cannot wedge the L2 answer channel.
  always_comb begin
    if (to_ptw) begin
      ans_rdy = !ptw_ans_q.valid || bus.ptw_l2arb_ans_rdy_i;
    end else if (to_dc) begin
      ans_rdy = !dc_ans_q.valid || bus.dc_l2arb_ans_rdy_i;
    end else if (to_ic) begin
      ans_rdy = !ic_ans_q.valid || bus.ic_l2arb_ans_rdy_i;
    end else begin
      ans_rdy = 1'b1;
    end
  end

  assign ans_hs                  = bus.l2c_l2arb_ans_i.valid && ans_rdy;
  assign bus.l2arb_l2c_ans_rdy_o = ans_rdy;

  // Buffer update priority: drain, then load (load wins over a same-cycle
  // drain), then flush for the buffers that do not carry write-back acks.
  always_comb begin
    ptw_ans_d = ptw_ans_q;
    if (bus.ptw_l2arb_ans_rdy_i) begin
      ptw_ans_d.valid = 1'b0;
    end
    if (ans_hs && to_ptw) begin
      ptw_ans_d = bus.l2c_l2arb_ans_i;
    end
    if (flush_i) begin
      ptw_ans_d = '0;
    end
  end

  always_comb begin
    dc_ans_d = dc_ans_q;
    if (bus.dc_l2arb_ans_rdy_i) begin
      dc_ans_d.valid = 1'b0;
    end
    if (ans_hs && to_dc) begin
      dc_ans_d = bus.l2c_l2arb_ans_i;
    end
  end

  always_comb begin
    ic_ans_d = ic_ans_q;
    if (bus.ic_l2arb_ans_rdy_i) begin
      ic_ans_d.valid = 1'b0;
    end
    if (ans_hs && to_ic) begin
      ic_ans_d = bus.l2c_l2arb_ans_i;
    end
    if (flush_i) begin
      ic_ans_d = '0;
    end
  end

  assign bus.l2arb_ptw_ans_o = ptw_ans_q;
  assign bus.l2arb_dc_ans_o  = dc_ans_q;
  assign bus.l2arb_ic_ans_o  = ic_ans_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= SRC_PTW;
      req_q     <= '0;
      ptw_ans_q <= '0;
      dc_ans_q  <= '0;
      ic_ans_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      req_q     <= req_d;
      ptw_ans_q <= ptw_ans_d;
      dc_ans_q  <= dc_ans_d;
      ic_ans_q  <= ic_ans_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_arbiter
// Description : Directed self-checking bench for l2_arbiter. Inputs change
//               1 time unit after the rising edge; outputs are sampled a
//               further 1-3 units later, away from the edge.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_l2_arbiter;
  import memory_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;

  always #5 clk_i = ~clk_i;

  l2_arbiter_if bus ();

  l2_arbiter dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rdyv();
    return {bus.l2arb_ic_req_rdy_o, bus.l2arb_dc_req_rdy_o, bus.l2arb_ptw_req_rdy_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Round-robin expectation after the first PTW grant (pointer = 1).
  logic [2:0]  exp_oh   [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [31:0] exp_addr [6] = '{32'h2000, 32'h3000, 32'h1000, 32'h2000, 32'h3000, 32'h1000};

  initial begin
    bus.ptw_l2arb_req_i     = '0;
    bus.dc_l2arb_req_i      = '0;
    bus.ic_l2arb_req_i      = '0;
    bus.l2c_l2arb_req_rdy_i = 1'b0;
    bus.l2c_l2arb_ans_i     = '0;
    bus.ptw_l2arb_ans_rdy_i = 1'b0;
    bus.dc_l2arb_ans_rdy_i  = 1'b0;
    bus.ic_l2arb_ans_rdy_i  = 1'b0;

    // ---------------- Reset state ----------------
    #3;
    check("rst_req", bus.l2arb_l2c_req_o, '0);
    check("rst_ptw_ans", bus.l2arb_ptw_ans_o, '0);
    check("rst_dc_ans", bus.l2arb_dc_ans_o, '0);
    check("rst_ic_ans", bus.l2arb_ic_ans_o, '0);
    check("rst_req_rdy", rdyv(), 3'b000);
    check("rst_ans_rdy", bus.l2arb_l2c_ans_rdy_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // ---------------- PTW-only request ----------------
    bus.ptw_l2arb_req_i.valid    = 1'b1;
    bus.ptw_l2arb_req_i.req_type = PTWLoad;
    bus.ptw_l2arb_req_i.paddr    = 32'h1000;
    bus.l2c_l2arb_req_rdy_i      = 1'b1;
    #1;
    check("t1_rdy", rdyv(), 3'b001);
    tick();
    check("t1_req_valid", bus.l2arb_l2c_req_o.valid, 1'b1);
    check("t1_req_paddr", bus.l2arb_l2c_req_o.paddr, 32'h1000);
    check("t1_req_type", bus.l2arb_l2c_req_o.req_type, PTWLoad);

    // ---------------- All three valid, L2 always ready ----------------
    bus.dc_l2arb_req_i.valid    = 1'b1;
    bus.dc_l2arb_req_i.req_type = DReadLine;
    bus.dc_l2arb_req_i.paddr    = 32'h2000;
    bus.ic_l2arb_req_i.valid    = 1'b1;
    bus.ic_l2arb_req_i.req_type = IReadLine;
    bus.ic_l2arb_req_i.paddr    = 32'h3000;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t2_rdy_%0d", i), rdyv(), exp_oh[i]);
      tick();
      check($sformatf("t2_req_%0d", i), bus.l2arb_l2c_req_o.paddr, exp_addr[i]);
    end

    // ---------------- L2 stall with DReadLine held ----------------
    #1;
    check("t3_pre_rdy", rdyv(), 3'b010);
    tick();
    bus.l2c_l2arb_req_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_rdy_%0d", i), rdyv(), 3'b000);
      check($sformatf("t3_paddr_%0d", i), bus.l2arb_l2c_req_o.paddr, 32'h2000);
      check($sformatf("t3_type_%0d", i), bus.l2arb_l2c_req_o.req_type, DReadLine);
      check($sformatf("t3_valid_%0d", i), bus.l2arb_l2c_req_o.valid, 1'b1);
      tick();
    end
    bus.l2c_l2arb_req_rdy_i = 1'b1;
    #1;
    check("t3_resume_rdy", rdyv(), 3'b100);
    tick();
    check("t3_resume_req", bus.l2arb_l2c_req_o.paddr, 32'h3000);
    bus.ptw_l2arb_req_i.valid = 1'b0;
    bus.dc_l2arb_req_i.valid  = 1'b0;
    bus.ic_l2arb_req_i.valid  = 1'b0;
    tick();
    check("t3_drained", bus.l2arb_l2c_req_o.valid, 1'b0);

    // ---------------- Answer routing / back-pressure ----------------
    bus.l2c_l2arb_ans_i.valid    = 1'b1;
    bus.l2c_l2arb_ans_i.ans_type = l2arb_s0_ILineRead;
    bus.l2c_l2arb_ans_i.data     = 64'hA;
    #1;
    check("t4_rdy_first", bus.l2arb_l2c_ans_rdy_o, 1'b1);
    tick();
    check("t4_ic_valid", bus.l2arb_ic_ans_o.valid, 1'b1);
    check("t4_ic_data", bus.l2arb_ic_ans_o.data, 64'hA);
    bus.l2c_l2arb_ans_i.data = 64'hB;
    #1;
    check("t4_rdy_second", bus.l2arb_l2c_ans_rdy_o, 1'b0);
    tick();
    check("t4_ic_held", bus.l2arb_ic_ans_o.data, 64'hA);
    bus.l2c_l2arb_ans_i.ans_type = l2arb_s0_PTWLoad;
    bus.l2c_l2arb_ans_i.data     = 64'hC;
    #1;
    check("t4_rdy_ptw", bus.l2arb_l2c_ans_rdy_o, 1'b1);
    tick();
    check("t4_ptw_valid", bus.l2arb_ptw_ans_o.valid, 1'b1);
    check("t4_ptw_data", bus.l2arb_ptw_ans_o.data, 64'hC);
    check("t4_ic_still", bus.l2arb_ic_ans_o.data, 64'hA);
    bus.l2c_l2arb_ans_i.valid = 1'b0;
    bus.ptw_l2arb_ans_rdy_i   = 1'b1;
    bus.ic_l2arb_ans_rdy_i    = 1'b1;
    tick();
    check("t4_ptw_drained", bus.l2arb_ptw_ans_o.valid, 1'b0);
    check("t4_ic_drained", bus.l2arb_ic_ans_o.valid, 1'b0);
    bus.ptw_l2arb_ans_rdy_i = 1'b0;
    bus.ic_l2arb_ans_rdy_i  = 1'b0;

    // ---------------- Flush with write-back in flight ----------------
    bus.l2c_l2arb_req_rdy_i     = 1'b0;
    bus.dc_l2arb_req_i.valid    = 1'b1;
    bus.dc_l2arb_req_i.req_type = DWriteLine;
    bus.dc_l2arb_req_i.paddr    = 32'h4000;
    bus.dc_l2arb_req_i.wbb_tag  = 3'd3;
    bus.l2c_l2arb_ans_i.valid    = 1'b1;
    bus.l2c_l2arb_ans_i.ans_type = l2arb_s0_ILineRead;
    bus.l2c_l2arb_ans_i.data     = 64'hD;
    #1;
    check("t5_dc_rdy", rdyv(), 3'b010);
    tick();
    bus.dc_l2arb_req_i.valid     = 1'b0;
    bus.l2c_l2arb_ans_i.ans_type = l2arb_s0_DLineWritten;
    bus.l2c_l2arb_ans_i.data     = 64'hE;
    bus.l2c_l2arb_ans_i.wbb_tag  = 3'd3;
    tick();
    bus.l2c_l2arb_ans_i.valid = 1'b0;
    check("t5_pre_ic", bus.l2arb_ic_ans_o.valid, 1'b1);
    check("t5_pre_dc", bus.l2arb_dc_ans_o.valid, 1'b1);
    check("t5_pre_req", bus.l2arb_l2c_req_o.valid, 1'b1);
    flush_i = 1'b1;
    bus.ptw_l2arb_req_i.valid = 1'b1;
    bus.dc_l2arb_req_i.valid  = 1'b1;
    bus.ic_l2arb_req_i.valid  = 1'b1;
    #1;
    check("t5_flush_rdy", rdyv(), 3'b000);
    tick();
    flush_i = 1'b0;
    bus.ptw_l2arb_req_i.valid = 1'b0;
    bus.dc_l2arb_req_i.valid  = 1'b0;
    bus.ic_l2arb_req_i.valid  = 1'b0;
    check("t5_req_valid", bus.l2arb_l2c_req_o.valid, 1'b1);
    check("t5_req_type", bus.l2arb_l2c_req_o.req_type, DWriteLine);
    check("t5_req_tag", bus.l2arb_l2c_req_o.wbb_tag, 3'd3);
    check("t5_ic_cleared", bus.l2arb_ic_ans_o.valid, 1'b0);
    check("t5_dc_valid", bus.l2arb_dc_ans_o.valid, 1'b1);
    check("t5_dc_type", bus.l2arb_dc_ans_o.ans_type, l2arb_s0_DLineWritten);
    check("t5_dc_tag", bus.l2arb_dc_ans_o.wbb_tag, 3'd3);

    // Flush with an empty request register still blocks every grant.
    bus.l2c_l2arb_req_rdy_i = 1'b1;
    tick();
    check("t5_wb_drained", bus.l2arb_l2c_req_o.valid, 1'b0);
    flush_i = 1'b1;
    bus.ptw_l2arb_req_i.valid = 1'b1;
    bus.dc_l2arb_req_i.valid  = 1'b1;
    bus.ic_l2arb_req_i.valid  = 1'b1;
    #1;
    check("t5_flush_empty_rdy", rdyv(), 3'b000);
    tick();
    check("t5_flush_empty_req", bus.l2arb_l2c_req_o.valid, 1'b0);
    flush_i = 1'b0;

    // ---------------- Asynchronous reset mid-stream ----------------
    bus.l2c_l2arb_req_rdy_i     = 1'b0;
    bus.ptw_l2arb_req_i.valid   = 1'b0;
    bus.ic_l2arb_req_i.valid    = 1'b0;
    bus.dc_l2arb_req_i.req_type = DReadLine;
    bus.dc_l2arb_req_i.paddr    = 32'h2000;
    bus.l2c_l2arb_ans_i.valid    = 1'b1;
    bus.l2c_l2arb_ans_i.ans_type = l2arb_s0_PTWLoad;
    bus.l2c_l2arb_ans_i.data     = 64'hF;
    tick();
    bus.l2c_l2arb_ans_i.ans_type = l2arb_s0_ILineRead;
    bus.l2c_l2arb_ans_i.data     = 64'h10;
    tick();
    bus.l2c_l2arb_ans_i.valid = 1'b0;
    bus.ptw_l2arb_req_i.valid = 1'b1;
    bus.ic_l2arb_req_i.valid  = 1'b1;
    check("t6_pre_req", bus.l2arb_l2c_req_o.valid, 1'b1);
    check("t6_pre_ptw", bus.l2arb_ptw_ans_o.valid, 1'b1);
    check("t6_pre_dc", bus.l2arb_dc_ans_o.valid, 1'b1);
    check("t6_pre_ic", bus.l2arb_ic_ans_o.valid, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_req", bus.l2arb_l2c_req_o.valid, 1'b0);
    check("t6_rst_ptw", bus.l2arb_ptw_ans_o.valid, 1'b0);
    check("t6_rst_dc", bus.l2arb_dc_ans_o.valid, 1'b0);
    check("t6_rst_ic", bus.l2arb_ic_ans_o.valid, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("t6_first_grant", rdyv(), 3'b001);
    tick();
    check("t6_first_req", bus.l2arb_l2c_req_o.paddr, 32'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
